// File: rtl/ca_pkg.sv
// Shared constants, preset table and FSM state type for the CA rule control slice.
package ca_pkg;

  // Rule in force out of reset unless the instance overrides it.
  localparam logic [7:0] DEFAULT_RESET_RULE = 8'd30;

  // Auto-cycle presets, entry 0 in the low byte:
  // 30, 90, 110, 184, 45, 73, 150, 22.
  localparam logic [63:0] PRESET_TABLE = {8'd22, 8'd150, 8'd73, 8'd45,
                                          8'd184, 8'd110, 8'd90, 8'd30};

  // Commit sequencing: wait for a request, hold it one frame, then reseed one frame.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_RESEED = 2'd2
  } ca_state_e;

  // Look up one preset rule by index.
  function automatic logic [7:0] preset_rule(input logic [2:0] idx);
    return PRESET_TABLE[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/frame_debounce.sv
// Button debouncer: two-flop synchronizer, then a level that only flips after
// DEBOUNCE_FRAMES consecutive frame-rate samples disagree with it.
module frame_debounce #(
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  input  logic frame_tick,
  output logic level,
  output logic rise
);

  localparam logic [2:0] CNT_LAST = 3'(DEBOUNCE_FRAMES - 1);

  logic       sync1_reg;
  logic       sync2_reg;
  logic       level_reg;
  logic       level_next;
  logic [2:0] cnt_reg;
  logic [2:0] cnt_next;
  logic       flip;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= async_in;
      sync2_reg <= sync1_reg;
    end
  end

  // Count disagreeing samples on frame ticks; any agreeing sample restarts the count.
  always_comb begin
    flip       = 1'b0;
    level_next = level_reg;
    cnt_next   = cnt_reg;
    if (frame_tick) begin
      if (sync2_reg != level_reg) begin
        if (cnt_reg == CNT_LAST) begin
          flip       = 1'b1;
          level_next = ~level_reg;
          cnt_next   = 3'd0;
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end else begin
        cnt_next = 3'd0;
      end
    end
  end

  // Hold the debounced level and its agreement count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_reg <= 1'b0;
      cnt_reg   <= 3'd0;
    end else begin
      level_reg <= level_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign level = level_reg;
  // Rise is combinational so the caller sees it during the tick that causes it.
  assign rise  = flip & ~level_reg;

endmodule

// File: rtl/ca_rule_ctrl.sv
// Rule control stage ahead of the 1D cellular-automaton renderer. Every
// visible change (rule, palette bit, reseed) lands on a frame tick so a frame
// is never drawn with a mixed rule.
module ca_rule_ctrl
  import ca_pkg::*;
#(
  parameter logic [7:0] RESET_RULE      = DEFAULT_RESET_RULE,
  parameter int         DEBOUNCE_FRAMES = 2,
  parameter int         AUTO_FRAMES     = 600,
  parameter logic       VSYNC_ACTIVE    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic [7:0] rule_in,
  input  logic       load_btn,
  input  logic       auto_en,
  output logic [7:0] rule,
  output logic       reseed,
  output logic       rule_sel,
  output logic       frame_tick,
  output logic       pending
);

  localparam int              CNT_W     = $clog2(AUTO_FRAMES);
  localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_FRAMES - 1);

  logic [7:0]       rule_s1_reg;
  logic [7:0]       rule_s2_reg;
  logic             auto_s1_reg;
  logic             auto_s2_reg;
  logic             vs_s1_reg;
  logic             vs_s2_reg;
  logic             vs_hist_reg;
  logic             tick_reg;

  logic [CNT_W-1:0] auto_cnt_reg;
  logic [CNT_W-1:0] auto_cnt_next;
  logic [2:0]       idx_reg;
  logic [2:0]       idx_next;

  ca_state_e        state_reg;
  ca_state_e        state_next;
  logic [7:0]       rule_reg;
  logic [7:0]       rule_next;
  logic [7:0]       pend_rule_reg;
  logic [7:0]       pend_rule_next;
  logic             sel_reg;
  logic             sel_next;
  logic             reseed_reg;
  logic             reseed_next;

  logic             btn_level;
  logic             btn_rise;
  logic             man_req;
  logic             auto_wrap;
  logic             auto_req;
  logic             req;
  logic [7:0]       req_rule;

  // Synchronize rule byte, auto enable and vsync; vsync keeps one extra history stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rule_s1_reg <= 8'd0;
      rule_s2_reg <= 8'd0;
      auto_s1_reg <= 1'b0;
      auto_s2_reg <= 1'b0;
      vs_s1_reg   <= ~VSYNC_ACTIVE;
      vs_s2_reg   <= ~VSYNC_ACTIVE;
      vs_hist_reg <= ~VSYNC_ACTIVE;
    end else begin
      rule_s1_reg <= rule_in;
      rule_s2_reg <= rule_s1_reg;
      auto_s1_reg <= auto_en;
      auto_s2_reg <= auto_s1_reg;
      vs_s1_reg   <= vsync;
      vs_s2_reg   <= vs_s1_reg;
      vs_hist_reg <= vs_s2_reg;
    end
  end

  // One-clock frame tick on the synced vsync entering its active level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= (vs_s2_reg == VSYNC_ACTIVE) && (vs_hist_reg != VSYNC_ACTIVE);
    end
  end

  frame_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_load_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_in  (load_btn),
    .frame_tick(tick_reg),
    .level     (btn_level),
    .rise      (btn_rise)
  );

  // A manual request only ever fires while the held level is still low.
  assign man_req   = btn_rise & ~btn_level;
  assign auto_wrap = tick_reg & auto_s2_reg & (auto_cnt_reg == AUTO_LAST);
  // Manual wins a same-tick collision; the auto request is dropped outright.
  assign auto_req  = auto_wrap & ~man_req;
  assign req       = man_req | auto_req;
  assign req_rule  = man_req ? rule_s2_reg : preset_rule(idx_reg + 3'd1);

  // Frame counter and preset index for auto-cycling; counter parks at 0 when disabled.
  always_comb begin
    auto_cnt_next = auto_cnt_reg;
    idx_next      = idx_reg;
    if (!auto_s2_reg) begin
      auto_cnt_next = '0;
    end else if (tick_reg) begin
      auto_cnt_next = auto_wrap ? '0 : auto_cnt_reg + CNT_W'(1);
    end
    if (auto_req) begin
      idx_next = idx_reg + 3'd1;
    end
  end

  // Register auto-cycle state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      auto_cnt_reg <= '0;
      idx_reg      <= 3'd0;
    end else begin
      auto_cnt_reg <= auto_cnt_next;
      idx_reg      <= idx_next;
    end
  end

  // Commit sequencer; moves only on frame ticks. Leaving reset, IDLE with reseed
  // still high steps into RESEED so the startup seed covers one whole frame.
  always_comb begin
    state_next     = state_reg;
    rule_next      = rule_reg;
    pend_rule_next = pend_rule_reg;
    sel_next       = sel_reg;
    reseed_next    = reseed_reg;
    if (tick_reg) begin
      case (state_reg)
        ST_IDLE: begin
          if (req) begin
            pend_rule_next = req_rule;
            reseed_next    = 1'b0;
            state_next     = ST_ARMED;
          end else if (reseed_reg) begin
            state_next = ST_RESEED;
          end
        end
        ST_ARMED: begin
          if (req) begin
            pend_rule_next = req_rule;
          end else begin
            rule_next   = pend_rule_reg;
            sel_next    = ~sel_reg;
            reseed_next = 1'b1;
            state_next  = ST_RESEED;
          end
        end
        ST_RESEED: begin
          reseed_next = 1'b0;
          if (req) begin
            pend_rule_next = req_rule;
            state_next     = ST_ARMED;
          end else begin
            state_next = ST_IDLE;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Register sequencer state and the published rule.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      rule_reg      <= RESET_RULE;
      pend_rule_reg <= RESET_RULE;
      sel_reg       <= 1'b0;
      reseed_reg    <= 1'b1;
    end else begin
      state_reg     <= state_next;
      rule_reg      <= rule_next;
      pend_rule_reg <= pend_rule_next;
      sel_reg       <= sel_next;
      reseed_reg    <= reseed_next;
    end
  end

  assign rule       = rule_reg;
  assign reseed     = reseed_reg;
  assign rule_sel   = sel_reg;
  assign frame_tick = tick_reg;
  assign pending    = (state_reg == ST_ARMED);

endmodule

// File: tb/tb_ca_rule_ctrl.sv
// Self-checking bench for ca_rule_ctrl: a frame-level behavioural model is
// compared against the outputs every clock, plus hand-computed checkpoints.
module tb_ca_rule_ctrl;

  localparam int DEB = 2;
  localparam int AF  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic [7:0] rule_in = 8'd0;
  logic       load_btn = 1'b0;
  logic       auto_en = 1'b0;
  logic [7:0] rule;
  logic       reseed;
  logic       rule_sel;
  logic       frame_tick;
  logic       pending;

  ca_rule_ctrl #(
    .RESET_RULE     (8'd30),
    .DEBOUNCE_FRAMES(DEB),
    .AUTO_FRAMES    (AF),
    .VSYNC_ACTIVE   (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vsync     (vsync),
    .rule_in   (rule_in),
    .load_btn  (load_btn),
    .auto_en   (auto_en),
    .rule      (rule),
    .reseed    (reseed),
    .rule_sel  (rule_sel),
    .frame_tick(frame_tick),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_ticks = 0;
  int frame_no = 0;
  bit model_valid = 1'b0;

  // Behavioural model state, expressed per frame rather than per register.
  int         m_since = 100;   // clocks since vsync was first seen high
  bit         m_prev_v = 1'b0;
  bit         m_tick = 1'b0;
  bit         m_lvl = 1'b0;
  int         m_bcnt = 0;
  int         m_acnt = 0;
  int         m_idx = 0;
  bit         m_pending = 1'b0;
  bit         m_sel = 1'b0;
  int         m_reseed_frames = 0;  // frame ticks reseed remains high for
  logic [7:0] m_rule = 8'd30;
  logic [7:0] m_pend_val = 8'd30;

  logic [7:0] preset_lut [8] = '{8'd30, 8'd90, 8'd110, 8'd184, 8'd45, 8'd73, 8'd150, 8'd22};
  logic [7:0] exp_auto   [8] = '{8'd90, 8'd110, 8'd184, 8'd45, 8'd73, 8'd150, 8'd22, 8'd30};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_since = 100; m_prev_v = 1'b0; m_tick = 1'b0;
    m_lvl = 1'b0; m_bcnt = 0; m_acnt = 0; m_idx = 0;
    m_pending = 1'b0; m_sel = 1'b0; m_reseed_frames = 2;
    m_rule = 8'd30; m_pend_val = 8'd30;
  endtask

  // What one frame boundary does, straight from the rules.
  task automatic frame_event();
    bit rise;
    bit wrap;
    bit rq;
    logic [7:0] val;
    rise = 1'b0;
    if (load_btn != m_lvl) begin
      m_bcnt++;
      if (m_bcnt == DEB) begin
        m_lvl = !m_lvl;
        m_bcnt = 0;
        rise = m_lvl;
      end
    end else begin
      m_bcnt = 0;
    end
    wrap = 1'b0;
    if (auto_en) begin
      m_acnt++;
      if (m_acnt == AF) begin
        m_acnt = 0;
        wrap = 1'b1;
      end
    end else begin
      m_acnt = 0;
    end
    rq = rise || wrap;
    if (wrap && !rise) m_idx = (m_idx + 1) % 8;
    val = rise ? rule_in : preset_lut[m_idx];
    if (m_reseed_frames > 0) m_reseed_frames--;
    if (m_pending) begin
      if (rq) begin
        m_pend_val = val;
      end else begin
        m_rule = m_pend_val;
        m_sel = !m_sel;
        m_pending = 1'b0;
        m_reseed_frames = 1;
      end
    end else if (rq) begin
      m_pending = 1'b1;
      m_pend_val = val;
    end
    if (rq) m_reseed_frames = 0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      model_valid = 1'b1;
    end else begin
      if (m_tick) frame_event();
      if (vsync && !m_prev_v) m_since = 0;
      else if (m_since < 100) m_since++;
      m_prev_v = vsync;
      m_tick = (m_since == 2);
    end
  endtask

  // Advance one clock: model follows the edge, outputs are compared mid-cycle.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (frame_tick === 1'b1) n_ticks++;
    if (model_valid)
      check("model", {20'd0, frame_tick, pending, reseed, rule_sel, rule},
            {20'd0, m_tick, m_pending, (m_reseed_frames > 0), m_sel, m_rule});
  endtask

  // One short frame; also pins the 3-clock, 1-clock-wide tick.
  task automatic frame();
    repeat (10) step();
    vsync = 1'b1;
    step(); step();
    check("tick_early", frame_tick, 0);
    step();
    check("tick_3clk", frame_tick, 1);
    step();
    check("tick_width", frame_tick, 0);
    step();
    vsync = 1'b0;
    repeat (8) step();
    frame_no++;
    $display("frame %0d: rule=%0d sel=%0b reseed=%0b pending=%0b", frame_no, rule, rule_sel, reseed, pending);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(); step();
    check("rst_rule", rule, 30);
    check("rst_reseed", reseed, 1);
    check("rst_sel", rule_sel, 0);
    check("rst_tick", frame_tick, 0);
    check("rst_pending", pending, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset then three idle frames.
    do_reset();
    n_ticks = 0;
    frame();
    check("a_reseed_t1", reseed, 1);
    check("a_rule_t1", rule, 30);
    check("a_sel_t1", rule_sel, 0);
    frame();
    check("a_reseed_t2", reseed, 0);
    frame();
    check("a_tick_count", n_ticks, 3);

    // Manual load of rule 110 with the button held.
    rule_in = 8'd110; load_btn = 1'b1;
    frame();
    check("b_pend_t1", pending, 0);
    frame();
    check("b_pend_t2", pending, 1);
    check("b_rule_t2", rule, 30);
    frame();
    check("b_rule_t3", rule, 110);
    check("b_sel_t3", rule_sel, 1);
    check("b_reseed_t3", reseed, 1);
    check("b_pend_t3", pending, 0);
    frame();
    check("b_reseed_t4", reseed, 0);
    load_btn = 1'b0;
    frame(); frame();

    // One-frame glitch on the button must be ignored.
    do_reset();
    frame(); frame();
    load_btn = 1'b1;
    frame();
    load_btn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      frame();
      check("c_pend", pending, 0);
      check("c_rule", rule, 30);
    end

    // Auto-cycle through all presets and wrap.
    auto_en = 1'b1;
    for (int f = 1; f <= 33; f++) begin
      frame();
      if (f == 4) begin
        check("d_pend_f4", pending, 1);
        check("d_rule_f4", rule, 30);
      end
      if (f >= 5 && (f % 4) == 1) begin
        check("d_rule", rule, exp_auto[(f - 5) / 4]);
        check("d_sel", rule_sel, ((f - 1) / 4) % 2);
      end
    end

    // Manual request lands on the same tick as an auto wrap.
    frame();
    load_btn = 1'b1; rule_in = 8'h96;
    frame();
    frame();
    check("e_pend_collide", pending, 1);
    load_btn = 1'b0;
    frame();
    check("e_rule_150", rule, 150);
    frame(); frame();
    check("e_cnt_restart", pending, 0);
    frame();
    check("e_auto_again", pending, 1);
    check("e_rule_hold", rule, 150);

    // Reset while armed discards the pending rule.
    auto_en = 1'b0;
    frame();
    rule_in = 8'd110; load_btn = 1'b1;
    frame(); frame();
    check("f_armed", pending, 1);
    load_btn = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("f_rule", rule, 30);
    check("f_pend", pending, 0);
    check("f_reseed", reseed, 1);
    check("f_sel", rule_sel, 0);
    frame();
    check("f_no_commit", rule, 30);
    check("f_pend_t1", pending, 0);
    check("f_reseed_t1", reseed, 1);
    frame();
    check("f_reseed_t2", reseed, 0);
    check("f_rule_t2", rule, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
